// File: rtl/note_tone_gen.sv
// Note-code to square-wave tone generator with period-boundary note changes.
// Note input is 2-flop synchronised; AUDIO never produces a runt pulse.
module note_tone_gen #(
  parameter int TONE_SHIFT = 0,
  parameter int CNT_W      = 18
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] note_in,
  output logic       AUDIO,
  output logic       NOTE_ACTIVE,
  output logic [3:0] cur_note,
  output logic [7:0] Led
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state, state_n;
  logic [3:0]       sync1, sync2, sync_note, pending;
  logic [3:0]       cur_n;
  logic             audio_n;
  logic [CNT_W-1:0] cnt, cnt_n, half_m1;
  logic [7:0]       led_n;
  logic             tc;

  function automatic logic [CNT_W-1:0] half_of(input logic [3:0] n);
    logic [17:0] h;
    case (n)
      4'd1:    h = 18'd191110;
      4'd2:    h = 18'd170265;
      4'd3:    h = 18'd151685;
      4'd4:    h = 18'd143172;
      4'd5:    h = 18'd127551;
      4'd6:    h = 18'd113636;
      4'd7:    h = 18'd101239;
      4'd8:    h = 18'd95557;
      default: h = 18'd1;
    endcase
    return CNT_W'(h >> TONE_SHIFT);
  endfunction

  // out-of-range codes behave as silence
  assign sync_note = (sync2 > 4'd8) ? 4'd0 : sync2;
  assign half_m1   = half_of(cur_note) - CNT_W'(1);
  assign tc        = (cnt == half_m1);

  always_comb begin
    state_n = state;
    cur_n   = cur_note;
    audio_n = AUDIO;
    cnt_n   = cnt;
    if (state == IDLE) begin
      audio_n = 1'b0;
      cnt_n   = '0;
      if (sync_note != 4'd0) begin
        state_n = PLAY;
        cur_n   = sync_note;
        audio_n = 1'b1;
      end
    end else if (tc) begin
      cnt_n = '0;
      if (AUDIO) begin
        audio_n = 1'b0;
      end else if (pending == cur_note) begin
        audio_n = 1'b1;
      end else if (pending == 4'd0) begin
        state_n = IDLE;
        cur_n   = 4'd0;
      end else begin
        // end of a full period: safe point to switch pitch
        cur_n   = pending;
        audio_n = 1'b1;
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  assign led_n = (cur_n == 4'd0) ? 8'd0 : (8'd1 << (cur_n - 4'd1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1       <= '0;
      sync2       <= '0;
      pending     <= '0;
      state       <= IDLE;
      cur_note    <= '0;
      AUDIO       <= 1'b0;
      cnt         <= '0;
      NOTE_ACTIVE <= 1'b0;
      Led         <= '0;
    end else begin
      sync1       <= note_in;
      sync2       <= sync1;
      pending     <= sync_note;
      state       <= state_n;
      cur_note    <= cur_n;
      AUDIO       <= audio_n;
      cnt         <= cnt_n;
      NOTE_ACTIVE <= (state_n == PLAY);
      Led         <= led_n;
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen with TONE_SHIFT=8.
module tb_note_tone_gen;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] note_in;
  logic       AUDIO, NOTE_ACTIVE;
  logic [3:0] cur_note;
  logic [7:0] Led;

  int errors = 0;
  int checks = 0;

  note_tone_gen #(.TONE_SHIFT(8), .CNT_W(18)) dut (
    .CLK(CLK), .RESET(RESET), .note_in(note_in), .AUDIO(AUDIO),
    .NOTE_ACTIVE(NOTE_ACTIVE), .cur_note(cur_note), .Led(Led)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] note;
    int         half;   // 0 = expect to stay idle
    logic [7:0] led;
    logic [3:0] cur;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (AUDIO === lvl && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_audio"}, AUDIO, 0);
    chk({nm, "_active"}, NOTE_ACTIVE, 0);
    chk({nm, "_cur"}, cur_note, 0);
    chk({nm, "_led"}, Led, 0);
  endtask

  // from just after a rising AUDIO edge: stop after ofs cycles, check idle at period end
  task automatic stop_note(input string nm, input int h, input int ofs);
    int n;
    repeat (ofs) tick();
    note_in = 4'd0;
    measure(1'b1, n);
    chk({nm, "_stop_high"}, n, h - ofs);
    repeat (h - 1) tick();
    chk({nm, "_stop_still"}, NOTE_ACTIVE, 1);
    tick();
    chk_idle({nm, "_stopped"});
    repeat (20) tick();
    chk({nm, "_stay_low"}, AUDIO, 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{4'd1,  746, 8'b0000_0001, 4'd1};
    tbl[1] = '{4'd2,  665, 8'b0000_0010, 4'd2};
    tbl[2] = '{4'd3,  592, 8'b0000_0100, 4'd3};
    tbl[3] = '{4'd4,  559, 8'b0000_1000, 4'd4};
    tbl[4] = '{4'd5,  498, 8'b0001_0000, 4'd5};
    tbl[5] = '{4'd6,  443, 8'b0010_0000, 4'd6};
    tbl[6] = '{4'd7,  395, 8'b0100_0000, 4'd7};
    tbl[7] = '{4'd8,  373, 8'b1000_0000, 4'd8};
    tbl[8] = '{4'd12, 0,   8'b0000_0000, 4'd0};

    RESET = 1'b1;
    note_in = 4'd0;
    repeat (3) tick();
    chk_idle("reset");
    RESET = 1'b0;
    repeat (3) tick();
    chk_idle("post_reset");

    foreach (tbl[i]) begin
      note_in = tbl[i].note;
      tick(); tick();
      chk($sformatf("n%0d_pre_rise", tbl[i].note), AUDIO, 0);
      tick();
      if (tbl[i].half == 0) begin
        repeat (5) tick();
        chk_idle($sformatf("n%0d_invalid", tbl[i].note));
        note_in = 4'd0;
        repeat (3) tick();
      end else begin
        chk($sformatf("n%0d_rise", tbl[i].note), AUDIO, 1);
        chk($sformatf("n%0d_active", tbl[i].note), NOTE_ACTIVE, 1);
        chk($sformatf("n%0d_cur", tbl[i].note), cur_note, tbl[i].cur);
        chk($sformatf("n%0d_led", tbl[i].note), Led, tbl[i].led);
        measure(1'b1, n);
        chk($sformatf("n%0d_high", tbl[i].note), n, tbl[i].half);
        measure(1'b0, n);
        chk($sformatf("n%0d_low", tbl[i].note), n, tbl[i].half);
        stop_note($sformatf("n%0d", tbl[i].note), tbl[i].half, 10);
      end
    end

    // E -> G mid-high: E period completes, then G
    note_in = 4'd3;
    repeat (3) tick();
    chk("chg_rise", AUDIO, 1);
    repeat (100) tick();
    note_in = 4'd5;
    measure(1'b1, n);
    chk("chg_e_high", n, 492);
    chk("chg_led_hold", Led, 8'b0000_0100);
    repeat (300) tick();
    chk("chg_led_hold_low", Led, 8'b0000_0100);
    chk("chg_cur_hold_low", cur_note, 3);
    measure(1'b0, n);
    chk("chg_e_low", n, 592 - 300);
    chk("chg_led_g", Led, 8'b0001_0000);
    chk("chg_cur_g", cur_note, 5);
    measure(1'b1, n);
    chk("chg_g_high", n, 498);
    measure(1'b0, n);
    chk("chg_g_low", n, 498);
    stop_note("chg", 498, 0);

    // E with a 100-cycle drop to 0 inside one period
    note_in = 4'd3;
    repeat (3) tick();
    chk("gl_rise", AUDIO, 1);
    repeat (50) tick();
    note_in = 4'd0;
    repeat (100) tick();
    note_in = 4'd3;
    measure(1'b1, n);
    chk("gl_high", n, 442);
    measure(1'b0, n);
    chk("gl_low", n, 592);
    chk("gl_active", NOTE_ACTIVE, 1);
    chk("gl_cur", cur_note, 3);
    measure(1'b1, n);
    chk("gl_high2", n, 592);
    measure(1'b0, n);
    chk("gl_low2", n, 592);
    stop_note("gl", 592, 0);

    // asynchronous reset mid-PLAY with AUDIO high
    note_in = 4'd1;
    repeat (3) tick();
    repeat (20) tick();
    chk("rst_pre_audio", AUDIO, 1);
    #2 RESET = 1'b1;
    #1;
    chk_idle("rst_async");
    note_in = 4'd0;
    tick(); tick();
    RESET = 1'b0;
    repeat (10) tick();
    chk_idle("rst_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
